// File: rtl/sw_rxbuf_pkg.sv
// Shared definitions for the single-flow FrameLink receive buffer.
package sw_rxbuf_pkg;

    localparam int unsigned LEN_WIDTH_DEF = 16;

    typedef logic [0:0] state_t;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    // Byte count to buffer words, rounding a partial word up.
    function automatic int unsigned bytes_to_words(input int unsigned len,
                                                   input int unsigned data_width);
        int unsigned bpw;
        bpw = data_width / 8;
        return (len + bpw - 1) / bpw;
    endfunction

endpackage

// File: rtl/sw_rxbuf_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module sw_rxbuf_mem #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register clears on reset so the host sees zero data until the first read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sw_rxbuf_fl_rx.sv
// FrameLink receive buffer: stores frames in a circular RAM, reports frame lengths, serves host reads.
module sw_rxbuf_fl_rx
    import sw_rxbuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BUF_WORDS  = 512,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic [DATA_WIDTH-1:0]                        RX_DATA,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]              RX_REM,
    input  logic                                         RX_SOF_N,
    input  logic                                         RX_SOP_N,
    input  logic                                         RX_EOP_N,
    input  logic                                         RX_EOF_N,
    input  logic                                         RX_SRC_RDY_N,
    output logic                                         RX_DST_RDY_N,
    output logic [LEN_WIDTH-1:0]                         RX_NEWLEN,
    output logic                                         RX_NEWLEN_DV,
    input  logic                                         RX_NEWLEN_RDY,
    input  logic [LEN_WIDTH-1:0]                         RX_RELLEN,
    input  logic                                         RX_RELLEN_DV,
    input  logic [$clog2(BUF_WORDS*DATA_WIDTH/8)-1:0]    RD_ADDR,
    input  logic                                         RD_REQ,
    output logic                                         RD_ARDY,
    output logic [DATA_WIDTH-1:0]                        RD_DATA,
    output logic                                         RD_SRC_RDY
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned REM_W = $clog2(BPW);
    localparam int unsigned AW    = $clog2(BUF_WORDS);
    localparam int unsigned RA_W  = $clog2(BUF_WORDS * BPW);
    localparam int unsigned FW    = AW + 1;
    localparam int unsigned LSW   = LEN_WIDTH + 1;

    state_t               state, state_next;
    logic [AW-1:0]        wr_ptr, wr_ptr_next;
    logic [FW-1:0]        free, free_next;
    logic [LEN_WIDTH-1:0] len_acc, len_acc_next;
    logic [LEN_WIDTH-1:0] newlen_next;
    logic                 newlen_dv_next;
    logic                 dst_rdy_n_next;

    logic                 xfer;
    logic                 wr_en;
    logic [LSW-1:0]       word_bytes;
    logic [LSW-1:0]       len_sum;
    logic [LEN_WIDTH-1:0] len_sat;
    int unsigned          rel_words;
    int unsigned          free_sum;

    // SOP/EOP only mark part boundaries; parts are word-padded so they do not affect length.
    logic unused_c;
    assign unused_c = ^{RX_SOP_N, RX_EOP_N, RD_ADDR[REM_W-1:0]};

    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        len_acc_next   = len_acc;
        newlen_next    = RX_NEWLEN;
        newlen_dv_next = RX_NEWLEN_DV;

        xfer  = !RX_SRC_RDY_N && !RX_DST_RDY_N;
        wr_en = xfer && ((state == ST_DATA) || !RX_SOF_N);

        word_bytes = RX_EOF_N ? LSW'(BPW) : LSW'(RX_REM) + LSW'(1);
        len_sum    = ((state == ST_IDLE) ? '0 : LSW'(len_acc)) + word_bytes;
        len_sat    = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

        if (wr_en) begin
            wr_ptr_next  = wr_ptr + AW'(1);
            len_acc_next = len_sat;
            if (!RX_EOF_N) begin
                state_next     = ST_IDLE;
                newlen_next    = len_sat;
                newlen_dv_next = 1'b1;
            end else begin
                state_next = ST_DATA;
            end
        end else if (RX_NEWLEN_DV && RX_NEWLEN_RDY) begin
            newlen_dv_next = 1'b0;
        end

        // Write and release land together; over-release by the host clamps at full.
        rel_words = RX_RELLEN_DV ? bytes_to_words(32'(RX_RELLEN), DATA_WIDTH) : 0;
        free_sum  = 32'(free) - 32'(wr_en) + rel_words;
        free_next = (free_sum > BUF_WORDS) ? FW'(BUF_WORDS) : FW'(free_sum);

        dst_rdy_n_next = (free_next == '0) || newlen_dv_next;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            free         <= FW'(BUF_WORDS);
            len_acc      <= '0;
            RX_NEWLEN    <= '0;
            RX_NEWLEN_DV <= 1'b0;
            RX_DST_RDY_N <= 1'b1;
            RD_ARDY      <= 1'b0;
            RD_SRC_RDY   <= 1'b0;
        end else begin
            state        <= state_next;
            wr_ptr       <= wr_ptr_next;
            free         <= free_next;
            len_acc      <= len_acc_next;
            RX_NEWLEN    <= newlen_next;
            RX_NEWLEN_DV <= newlen_dv_next;
            RX_DST_RDY_N <= dst_rdy_n_next;
            RD_ARDY      <= 1'b1;
            RD_SRC_RDY   <= RD_REQ;
        end
    end

    sw_rxbuf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_WORDS)
    ) u_mem (
        .clk   (CLK),
        .rst_n (RESET),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (RX_DATA),
        .re    (RD_REQ),
        .raddr (RD_ADDR[RA_W-1:REM_W]),
        .rdata (RD_DATA)
    );

endmodule

// File: tb/tb_sw_rxbuf_fl_rx.sv
// Directed bench for sw_rxbuf_fl_rx with DATA_WIDTH=64, BUF_WORDS=16.
module tb_sw_rxbuf_fl_rx;

    localparam int unsigned DW = 64;
    localparam int unsigned BW = 16;
    localparam int unsigned LW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] RX_DATA;
    logic [2:0]    RX_REM;
    logic          RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N;
    logic          RX_SRC_RDY_N;
    logic          RX_DST_RDY_N;
    logic [LW-1:0] RX_NEWLEN;
    logic          RX_NEWLEN_DV;
    logic          RX_NEWLEN_RDY;
    logic [LW-1:0] RX_RELLEN;
    logic          RX_RELLEN_DV;
    logic [6:0]    RD_ADDR;
    logic          RD_REQ;
    logic          RD_ARDY;
    logic [DW-1:0] RD_DATA;
    logic          RD_SRC_RDY;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sw_rxbuf_fl_rx #(.DATA_WIDTH(DW), .BUF_WORDS(BW), .LEN_WIDTH(LW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .RX_DATA       (RX_DATA),
        .RX_REM        (RX_REM),
        .RX_SOF_N      (RX_SOF_N),
        .RX_SOP_N      (RX_SOP_N),
        .RX_EOP_N      (RX_EOP_N),
        .RX_EOF_N      (RX_EOF_N),
        .RX_SRC_RDY_N  (RX_SRC_RDY_N),
        .RX_DST_RDY_N  (RX_DST_RDY_N),
        .RX_NEWLEN     (RX_NEWLEN),
        .RX_NEWLEN_DV  (RX_NEWLEN_DV),
        .RX_NEWLEN_RDY (RX_NEWLEN_RDY),
        .RX_RELLEN     (RX_RELLEN),
        .RX_RELLEN_DV  (RX_RELLEN_DV),
        .RD_ADDR       (RD_ADDR),
        .RD_REQ        (RD_REQ),
        .RD_ARDY       (RD_ARDY),
        .RD_DATA       (RD_DATA),
        .RD_SRC_RDY    (RD_SRC_RDY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic sof, input logic sop,
                         input logic eop, input logic eof, input logic [2:0] rem);
        RX_DATA      = d;
        RX_SOF_N     = !sof;
        RX_SOP_N     = !sop;
        RX_EOP_N     = !eop;
        RX_EOF_N     = !eof;
        RX_REM       = rem;
        RX_SRC_RDY_N = 1'b0;
    endtask

    task automatic rx_idle();
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1; RX_EOF_N = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [6:0] addr, input logic [DW-1:0] exp);
        RD_ADDR = addr;
        RD_REQ  = 1'b1;
        tick();
        check({tag, "_vld"}, 64'(RD_SRC_RDY), 64'd1);
        check(tag, RD_DATA, exp);
    endtask

    initial begin
        RESET = 1'b0;
        RX_DATA = '0; RX_REM = '0;
        rx_idle();
        RX_NEWLEN_RDY = 1'b0;
        RX_RELLEN = '0; RX_RELLEN_DV = 1'b0;
        RD_ADDR = '0; RD_REQ = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_dst", 64'(RX_DST_RDY_N), 64'd1);
        check("rst_newlen", 64'(RX_NEWLEN), 64'd0);
        check("rst_dv", 64'(RX_NEWLEN_DV), 64'd0);
        check("rst_ardy", 64'(RD_ARDY), 64'd0);
        check("rst_srdy", 64'(RD_SRC_RDY), 64'd0);
        check("rst_rdata", RD_DATA, 64'd0);
        RESET = 1'b1;
        tick();
        check("post_rst_dst", 64'(RX_DST_RDY_N), 64'd0);
        check("post_rst_ardy", 64'(RD_ARDY), 64'd1);

        // 3-word frame, REM=4 on EOF -> 21 bytes
        drive(64'h1111_0000_0000_0000, 1, 1, 0, 0, 3'd0); tick();
        drive(64'h2222_0000_0000_0001, 0, 0, 0, 0, 3'd0); tick();
        check("f1_dv_early", 64'(RX_NEWLEN_DV), 64'd0);
        drive(64'h3333_0000_0000_0002, 0, 0, 1, 1, 3'd4); tick();
        check("f1_dv", 64'(RX_NEWLEN_DV), 64'd1);
        check("f1_len", 64'(RX_NEWLEN), 64'd21);
        check("f1_dst", 64'(RX_DST_RDY_N), 64'd1);

        // Host withholds NEWLEN_RDY; an offered SOF word must not be taken
        drive(64'hDEAD_DEAD_DEAD_DEAD, 1, 1, 1, 1, 3'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_dst", 64'(RX_DST_RDY_N), 64'd1);
            check("hold_dv", 64'(RX_NEWLEN_DV), 64'd1);
            check("hold_len", 64'(RX_NEWLEN), 64'd21);
        end
        RX_NEWLEN_RDY = 1'b1;
        tick();
        RX_NEWLEN_RDY = 1'b0;
        rx_idle();
        check("hs_dv", 64'(RX_NEWLEN_DV), 64'd0);
        check("hs_dst", 64'(RX_DST_RDY_N), 64'd0);

        // Read back frame 1 at full rate, low address bits ignored on the last
        read_check("rd0", 7'd0, 64'h1111_0000_0000_0000);
        read_check("rd1", 7'd8, 64'h2222_0000_0000_0001);
        read_check("rd2", 7'd17, 64'h3333_0000_0000_0002);
        RD_REQ = 1'b0;
        tick();
        check("rd_idle", 64'(RD_SRC_RDY), 64'd0);

        // Two-part frame: 1 word + EOP, then 2 words with EOF REM=0 -> 17 bytes
        drive(64'h4444_0000_0000_0003, 1, 1, 1, 0, 3'd5); tick();
        drive(64'h5555_0000_0000_0004, 0, 1, 0, 0, 3'd0); tick();
        drive(64'h6666_0000_0000_0005, 0, 0, 1, 1, 3'd0); tick();
        rx_idle();
        check("f2_dv", 64'(RX_NEWLEN_DV), 64'd1);
        check("f2_len", 64'(RX_NEWLEN), 64'd17);
        RX_NEWLEN_RDY = 1'b1;
        tick();
        RX_NEWLEN_RDY = 1'b0;
        check("f2_hs_dv", 64'(RX_NEWLEN_DV), 64'd0);
        read_check("f2_rd0", 7'd24, 64'h4444_0000_0000_0003);
        read_check("f2_rd2", 7'd40, 64'h6666_0000_0000_0005);
        RD_REQ = 1'b0;

        // Non-SOF words in IDLE are dropped
        drive(64'h7777_0000_0000_0000, 0, 0, 0, 0, 3'd0); tick();
        check("nosof_dv0", 64'(RX_NEWLEN_DV), 64'd0);
        drive(64'h7777_0000_0000_0001, 0, 0, 1, 1, 3'd3); tick();
        check("nosof_dv1", 64'(RX_NEWLEN_DV), 64'd0);
        check("nosof_dst", 64'(RX_DST_RDY_N), 64'd0);
        rx_idle();

        // 10 words remain free: fill them in one open frame
        for (int i = 0; i < 10; i++) begin
            drive(64'hF000 + 64'(i), i == 0, i == 0, 0, 0, 3'd0);
            tick();
            check("fill_dst", 64'(RX_DST_RDY_N), 64'(i == 9));
        end
        drive(64'hBAD0, 0, 0, 0, 0, 3'd0);
        tick();
        check("full_dst", 64'(RX_DST_RDY_N), 64'd1);
        RX_RELLEN = 16'd9;
        RX_RELLEN_DV = 1'b1;
        tick();
        RX_RELLEN_DV = 1'b0;
        check("rel_dst", 64'(RX_DST_RDY_N), 64'd0);
        drive(64'hA0A0_0000_0000_0000, 0, 0, 0, 0, 3'd0); tick();
        check("wrap_dst0", 64'(RX_DST_RDY_N), 64'd0);
        drive(64'hB0B0_0000_0000_0001, 0, 0, 0, 0, 3'd0); tick();
        check("wrap_dst1", 64'(RX_DST_RDY_N), 64'd1);
        drive(64'hBAD1, 0, 0, 0, 0, 3'd0); tick();
        check("wrap_dst2", 64'(RX_DST_RDY_N), 64'd1);
        rx_idle();
        read_check("wrap_rd0", 7'd0, 64'hA0A0_0000_0000_0000);
        read_check("wrap_rd1", 7'd8, 64'hB0B0_0000_0000_0001);
        read_check("fill_last", 7'd120, 64'hF009);
        RD_REQ = 1'b0;
        tick();

        // Reset mid-frame
        RESET = 1'b0;
        tick();
        check("mrst_dst", 64'(RX_DST_RDY_N), 64'd1);
        check("mrst_dv", 64'(RX_NEWLEN_DV), 64'd0);
        check("mrst_len", 64'(RX_NEWLEN), 64'd0);
        check("mrst_ardy", 64'(RD_ARDY), 64'd0);
        check("mrst_rdata", RD_DATA, 64'd0);
        RESET = 1'b1;
        tick();
        check("mrst_rel_dst", 64'(RX_DST_RDY_N), 64'd0);
        drive(64'hBEEF, 1, 1, 1, 1, 3'd7); tick();
        rx_idle();
        check("r_len", 64'(RX_NEWLEN), 64'd8);
        check("r_dv", 64'(RX_NEWLEN_DV), 64'd1);
        read_check("r_rd0", 7'd0, 64'hBEEF);
        RD_REQ = 1'b0;
        RX_NEWLEN_RDY = 1'b1;
        tick();
        RX_NEWLEN_RDY = 1'b0;
        check("r_hs_dst", 64'(RX_DST_RDY_N), 64'd0);

        // Free count restarted at 16: exactly 15 more words fit
        for (int i = 0; i < 15; i++) begin
            drive(64'hC000 + 64'(i), i == 0, i == 0, 0, 0, 3'd0);
            tick();
            check("r_fill_dst", 64'(RX_DST_RDY_N), 64'(i == 14));
        end
        rx_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
